// File: rtl/trng_ctrl.sv
// Purpose : sequences a TRNG source (power, warm-up, health test) and hands its bytes out to two requesters.
// Latency : grant decided from the inputs of one cycle; ack/rnd_data/trng_consume appear after the next clk edge.
// Backpr.  : at most one byte per two cycles; requesters hold req until ack, the TRNG holds its byte until consume.
//
// Ports: clk/rst_n (async active-low); en, clear_fault, req[1:0] control inputs;
//        ack[1:0] + rnd_data[7:0] delivery; trng_enable/trng_consume/trng_data/trng_ready to the source;
//        fault and state_o (OFF=0, WARMUP=1, SERVE=2, FAULT=3) status.
module trng_ctrl #(
    parameter int WARMUP_CYCLES = 64,
    parameter int IDLE_TIMEOUT  = 256,
    parameter int STALL_LIMIT   = 1024,
    parameter int REP_LIMIT     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clear_fault,
    input  logic [1:0] req,
    output logic [1:0] ack,
    output logic [7:0] rnd_data,
    output logic       trng_enable,
    output logic       trng_consume,
    input  logic [7:0] trng_data,
    input  logic       trng_ready,
    output logic       fault,
    output logic [1:0] state_o
);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT);
    localparam logic [3:0]    REP_LIM    = 4'(REP_LIMIT);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        SERVE  = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [3:0]    rep_q, rep_d, rep_next;
    logic          last_vld_q, last_vld_d;
    logic          rr_last_q, rr_last_d;   // 1: requester 1 was granted last
    logic [1:0]    ack_d;
    logic          cons_d;
    logic [7:0]    data_d;
    logic          take;
    logic          win1;

    // A byte is only taken when the previous consume pulse has finished,
    // otherwise the source may still be presenting the byte just taken.
    assign take = trng_ready && (|req) && !trng_consume;
    // Requester 1 wins alone, or when both ask and requester 0 was served last.
    assign win1 = req[1] && (!req[0] || !rr_last_q);
    // rnd_data doubles as the last delivered byte for the repetition test.
    assign rep_next = (last_vld_q && (trng_data == rnd_data))
                    ? ((rep_q == 4'd15) ? rep_q : rep_q + 4'd1)
                    : 4'd1;

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        idle_d     = '0;
        stall_d    = '0;
        rep_d      = rep_q;
        last_vld_d = last_vld_q;
        rr_last_d  = rr_last_q;
        ack_d      = 2'b00;
        cons_d     = 1'b0;
        data_d     = rnd_data;
        case (state_q)
            OFF: begin
                warm_d = '0;
                if (en && (|req)) state_d = WARMUP;
            end
            WARMUP: begin
                if (!en) begin
                    state_d = OFF;
                end else begin
                    // Bytes produced while settling are discarded unseen.
                    cons_d = trng_ready && !trng_consume;
                    if (warm_q == WARM_LAST) state_d = SERVE;
                    else                     warm_d = warm_q + WW'(1);
                end
            end
            SERVE: begin
                if (!en) begin
                    state_d = OFF;
                end else if (take) begin
                    cons_d = 1'b1;
                    if (rep_next >= REP_LIM) begin
                        state_d = FAULT;
                    end else begin
                        ack_d      = win1 ? 2'b10 : 2'b01;
                        data_d     = trng_data;
                        last_vld_d = 1'b1;
                        rep_d      = rep_next;
                        rr_last_d  = win1;
                    end
                end else if ((|req) && !trng_ready) begin
                    stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
                    if (stall_q == STALL_LAST) state_d = FAULT;
                end else if (!(|req)) begin
                    idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
                    if (idle_q == IDLE_LAST) state_d = OFF;
                end
            end
            default: begin
                if (clear_fault) begin
                    state_d    = OFF;
                    rep_d      = 4'd0;
                    last_vld_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            warm_q       <= '0;
            idle_q       <= '0;
            stall_q      <= '0;
            rep_q        <= 4'd0;
            last_vld_q   <= 1'b0;
            rr_last_q    <= 1'b1;
            ack          <= 2'b00;
            rnd_data     <= 8'h00;
            trng_enable  <= 1'b0;
            trng_consume <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_q       <= warm_d;
            idle_q       <= idle_d;
            stall_q      <= stall_d;
            rep_q        <= rep_d;
            last_vld_q   <= last_vld_d;
            rr_last_q    <= rr_last_d;
            ack          <= ack_d;
            rnd_data     <= data_d;
            trng_enable  <= (state_d == WARMUP) || (state_d == SERVE);
            trng_consume <= cons_d;
            fault        <= (state_d == FAULT);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Purpose : self-checking bench for trng_ctrl: directed scenarios plus random traffic against a reference model.
// Latency : model advances once per clk edge; outputs sampled 1 time unit after each rising edge.
// Backpr.  : source data is held by the bench until the controller pulses trng_consume.
module tb_trng_ctrl;
    localparam int W_CYC = 64;
    localparam int I_LIM = 256;
    localparam int S_LIM = 1024;
    localparam int R_LIM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en = 1'b0;
    logic       clear_fault = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] ack;
    logic [7:0] rnd_data;
    logic       trng_enable;
    logic       trng_consume;
    logic [7:0] trng_data = 8'h00;
    logic       trng_ready = 1'b0;
    logic       fault;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    trng_ctrl #(
        .WARMUP_CYCLES(W_CYC),
        .IDLE_TIMEOUT (I_LIM),
        .STALL_LIMIT  (S_LIM),
        .REP_LIMIT    (R_LIM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clear_fault (clear_fault),
        .req         (req),
        .ack         (ack),
        .rnd_data    (rnd_data),
        .trng_enable (trng_enable),
        .trng_consume(trng_consume),
        .trng_data   (trng_data),
        .trng_ready  (trng_ready),
        .fault       (fault),
        .state_o     (state_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0..3 = OFF/WARMUP/SERVE/FAULT, counts kept as plain ints.
    int         m_mode, m_warm, m_idle, m_stall, m_rep, m_pref;
    bit         m_last_vld, m_cons;
    logic [7:0] m_data;
    logic [1:0] m_ack;

    function automatic void model_reset();
        m_mode = 0; m_warm = 0; m_idle = 0; m_stall = 0; m_rep = 0;
        m_pref = 0; m_last_vld = 0; m_cons = 0; m_data = 8'h00; m_ack = 2'b00;
    endfunction

    function automatic void model_step(input bit i_en, input bit i_clr, input logic [1:0] i_req,
                                       input bit i_rdy, input logic [7:0] i_dat);
        int nxt, rep_n, w;
        bit take, ncons;
        logic [1:0] nack;
        nxt = m_mode; nack = 2'b00; ncons = 0; take = 0;
        case (m_mode)
            0: begin
                m_warm = 0;
                if (i_en && i_req != 2'b00) nxt = 1;
            end
            1: begin
                if (!i_en) nxt = 0;
                else begin
                    ncons = i_rdy && !m_cons;
                    m_warm++;
                    if (m_warm == W_CYC) nxt = 2;
                end
            end
            2: begin
                if (!i_en) nxt = 0;
                else begin
                    take = i_rdy && (i_req != 2'b00) && !m_cons;
                    if (take) begin
                        ncons = 1;
                        rep_n = (m_last_vld && i_dat == m_data) ? m_rep + 1 : 1;
                        if (rep_n >= R_LIM) nxt = 3;
                        else begin
                            w = (i_req == 2'b11) ? m_pref : (i_req[1] ? 1 : 0);
                            nack = (w == 1) ? 2'b10 : 2'b01;
                            m_pref = 1 - w;
                            m_data = i_dat;
                            m_last_vld = 1;
                            m_rep = rep_n;
                        end
                    end else begin
                        m_stall = (i_req != 2'b00 && !i_rdy) ? m_stall + 1 : 0;
                        m_idle  = (i_req == 2'b00) ? m_idle + 1 : 0;
                        if (m_stall == S_LIM) nxt = 3;
                        else if (m_idle == I_LIM) nxt = 0;
                    end
                end
            end
            default: begin
                if (i_clr) begin
                    nxt = 0; m_rep = 0; m_last_vld = 0;
                end
            end
        endcase
        if (nxt != 2 || take) begin
            m_stall = 0; m_idle = 0;
        end
        m_mode = nxt;
        m_ack  = nack;
        m_cons = ncons;
    endfunction

    task automatic compare_all();
        check("ack", ack, m_ack);
        check("rnd_data", rnd_data, m_data);
        check("consume", trng_consume, m_cons);
        check("enable", trng_enable, (m_mode == 1 || m_mode == 2));
        check("fault", fault, (m_mode == 3));
        check("state", state_o, m_mode);
    endtask

    task automatic cyc(input bit i_en, input bit i_clr, input logic [1:0] i_req,
                       input bit i_rdy, input logic [7:0] i_dat);
        en = i_en; clear_fault = i_clr; req = i_req; trng_ready = i_rdy; trng_data = i_dat;
        @(posedge clk);
        if (rst_n) model_step(i_en, i_clr, i_req, i_rdy, i_dat);
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_data"}, rnd_data, 0);
        check({tag, "_en"}, trng_enable, 0);
        check({tag, "_cons"}, trng_consume, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_state"}, state_o, 0);
    endtask

    task automatic goto_serve(input logic [1:0] r);
        for (int c = 0; c < 100 && state_o != 2'd2; c++) cyc(1, 0, r, 0, 8'h00);
        check("serve_reach", state_o, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int warm_cnt, cons_cnt, ack_cnt, serve_cnt, idx, last_cons;
        bit seen;
        logic [7:0] src [4];
        logic [1:0] ack_log [$];
        logic [7:0] dat_log [$];
        logic [7:0] rdat;

        rst_n = 1'b0;
        model_reset();
        repeat (2) cyc(0, 0, 2'b00, 0, 8'h00);
        chk_reset("rst");
        rst_n = 1'b1;

        // First delivery after warm-up.
        warm_cnt = 0; cons_cnt = 0; seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            cyc(1, 0, 2'b01, c >= 69, 8'hA5);
            if (state_o == 2'd1) warm_cnt++;
            if (trng_consume) cons_cnt++;
            if (ack != 2'b00) begin
                seen = 1;
                check("first_ack", ack, 2'b01);
                check("first_data", rnd_data, 8'hA5);
            end
        end
        check("first_seen", seen, 1);
        check("warm_len", warm_cnt, W_CYC);
        check("first_cons", cons_cnt, 1);

        // Round-robin with both requesting, fresh pointer.
        rst_n = 1'b0;
        cyc(0, 0, 2'b00, 0, 8'h00);
        rst_n = 1'b1;
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        idx = 0; last_cons = -100;
        for (int c = 0; c < 200 && idx < 4; c++) begin
            cyc(1, 0, 2'b11, c >= 65, src[idx]);
            if (ack != 2'b00) begin
                ack_log.push_back(ack);
                dat_log.push_back(rnd_data);
            end
            if (trng_consume) begin
                check("cons_gap", (c - last_cons) >= 2, 1);
                last_cons = c;
                idx++;
            end
        end
        check("rr_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
            check("rr_ack", ack_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_data", dat_log[i], src[i]);
        end

        // Stuck source trips the repetition test.
        ack_cnt = 0; cons_cnt = 0;
        for (int c = 0; c < 50 && !fault; c++) begin
            cyc(1, 0, 2'b01, 1, 8'h5A);
            if (ack != 2'b00) begin
                ack_cnt++;
                check("rep_data", rnd_data, 8'h5A);
            end
            if (trng_consume) cons_cnt++;
        end
        check("rep_acks", ack_cnt, R_LIM - 1);
        check("rep_cons", cons_cnt, R_LIM);
        check("rep_fault", fault, 1);
        check("rep_state", state_o, 3);
        check("rep_enable", trng_enable, 0);
        repeat (5) cyc(1, 0, 2'b11, 1, 8'h77);
        check("fault_hold", state_o, 3);
        cyc(1, 1, 2'b00, 0, 8'h00);
        check("clear_state", state_o, 0);

        // Stall timeout.
        serve_cnt = 0;
        for (int c = 0; c < 1300 && state_o != 2'd3; c++) begin
            cyc(1, 0, 2'b01, 0, 8'h00);
            if (state_o == 2'd2) serve_cnt++;
        end
        check("stall_len", serve_cnt, S_LIM);
        check("stall_state", state_o, 3);
        cyc(0, 1, 2'b00, 0, 8'h00);
        check("stall_clear", state_o, 0);

        // Idle timeout, then restart.
        serve_cnt = 0;
        cyc(1, 0, 2'b01, 0, 8'h00);
        for (int c = 0; c < 500 && !(serve_cnt > 0 && state_o == 2'd0); c++) begin
            cyc(1, 0, 2'b00, 0, 8'h00);
            if (state_o == 2'd2) serve_cnt++;
        end
        check("idle_len", serve_cnt, I_LIM);
        check("idle_state", state_o, 0);
        check("idle_enable", trng_enable, 0);
        cyc(1, 0, 2'b10, 0, 8'h00);
        check("restart", state_o, 1);

        // Asynchronous reset mid-warm-up.
        repeat (5) cyc(1, 0, 2'b10, 1, 8'h3C);
        #3; rst_n = 1'b0; #1;
        chk_reset("rst_warm");
        model_reset();
        repeat (2) cyc(1, 0, 2'b01, 1, 8'h3C);
        rst_n = 1'b1;

        // Asynchronous reset while an ack is high.
        goto_serve(2'b01);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cyc(1, 0, 2'b01, 1, 8'hC3);
            if (ack != 2'b00) seen = 1;
        end
        check("grant_seen", seen, 1);
        #2; rst_n = 1'b0; #1;
        chk_reset("rst_grant");
        model_reset();
        repeat (2) cyc(1, 0, 2'b01, 1, 8'hC3);
        rst_n = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1, 0, 2'b01, 1, 8'hC3);
            if (ack != 2'b00) ack_cnt++;
        end
        check("no_ack_after_rst", ack_cnt, 0);

        // Random traffic against the model.
        rdat = 8'h00;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 9) >= 4) rdat = 8'($urandom);
            cyc($urandom_range(0, 999) < 998, $urandom_range(0, 99) < 2,
                2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, rdat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
